mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'h0000_0000: byte address of word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words, a power of two from 16 to 4096.
REQ-003 SHALL have parameter LATENCY, default 2: cycles from request to response, range 1..4.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port mem_req_i  input  1  request valid; one request accepted per cycle, no backpressure.
REQ-007 SHALL have port mem_addr_i  input  32  byte address.
REQ-008 SHALL have port mem_we_i  input  1  1 = write, 0 = read.
REQ-009 SHALL have port mem_be_i  input  4  byte enables; bit n gates wdata[8n+7:8n].
REQ-010 SHALL have port mem_wdata_i  input  32  write data.
REQ-011 SHALL have port mem_rvalid_o  output  1  one-cycle response strobe.
REQ-012 SHALL have port mem_err_o  output  1  response error; valid only while mem_rvalid_o=1, 0 otherwise.
REQ-013 SHALL have port mem_rdata_o  output  32  read data; 0 whenever mem_rvalid_o=0 or the response is for a write or an error.
REQ-014 SHALL have port busy_o  output  1  1 while any accepted request has not yet been responded to.
REQ-015 SHALL have port req_count_o  output  16  accepted-request counter; saturates at 16'hFFFF.

Function
REQ-016 SHALL accept a request in every cycle where mem_req_i=1 and rst=1.
REQ-017 SHALL perform the storage access at the rising edge that ends the acceptance cycle t.
REQ-018 SHALL compute the word index as (mem_addr_i - ADDR_BASE) >> 2.
REQ-019 SHALL, on a write, update only the enabled bytes; be=4'b0000 is a legal no-op write that still gets a response.
REQ-020 SHALL, on a read, return the word value before any write accepted in that same cycle t.
REQ-021 SHALL make a write accepted in cycle t visible to a read accepted in cycle t+1 or later.
REQ-022 SHALL assert mem_rvalid_o for exactly one cycle, in cycle t+LATENCY, for each request accepted in cycle t.
REQ-023 SHALL return responses strictly in acceptance order and SHALL sustain one response per cycle back-to-back.
REQ-024 SHALL implement the response path as a LATENCY-deep shift pipeline of {valid, err, rdata}; no FSM stalls and no drops.
REQ-025 SHALL hold busy_o=1 from cycle t+1 through cycle t+LATENCY for every request accepted in cycle t.
REQ-026 SHALL increment req_count_o by 1 per accepted request, holding at 16'hFFFF once reached with no wrap.

Reset
REQ-027 SHALL, in a cycle where rst=0 at a clock edge, clear the pipeline, req_count_o and busy_o, so that mem_rvalid_o=0, mem_err_o=0 and mem_rdata_o=0 in the next cycle.
REQ-028 SHALL ignore requests presented during reset; responses in flight when reset occurs SHALL be discarded and never emitted.
REQ-029 SHALL NOT reset storage contents.

Configuration
REQ-030 SHALL, with MEM_RESP_ERR_EN defined, flag an error for an address outside [ADDR_BASE, ADDR_BASE+4*DEPTH_WORDS) or with addr[1:0]!=0: no storage access, mem_err_o=1 with the response, rdata=0.
REQ-031 SHALL, without MEM_RESP_ERR_EN, ignore addr[1:0], wrap the word index modulo DEPTH_WORDS, and hold mem_err_o constantly 0.

Verification
REQ-032 SHALL pass this check (LATENCY=2): write 32'hDEADBEEF to 0x10 with be=4'hF at t0, then read 0x10 at t1 -> rvalid at t2 with rdata=0, rvalid at t3 with rdata=32'hDEADBEEF.
REQ-033 SHALL pass this check: with 0x20 holding 32'h11223344, write 32'hAABBCCDD with be=4'b0101 and read 0x20 in the following cycle -> read returns 32'h11BB33DD.
REQ-034 SHALL pass this check (LATENCY=3): 8 consecutive reads of 0x0..0x1C -> 8 consecutive rvalid cycles starting 3 cycles after the first request, in order, busy_o continuously high until the final response.
REQ-035 SHALL pass this check (with MEM_RESP_ERR_EN, DEPTH_WORDS=1024): reads of 0x1000 and of 0x6 -> each gets rvalid=1 and err=1 with rdata=0; the same stimulus without the macro -> err=0 and reads of words 0 and 1 respectively.
REQ-036 SHALL pass this check: rst=0 in the cycle after two requests are accepted -> no rvalid ever appears, and busy_o=0 and req_count_o=0 in the next cycle.
REQ-037 SHALL pass this check: 65540 accepted requests -> req_count_o=16'hFFFF and holding.

Source files
------------

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency word memory responder with byte enables (optional MEM_RESP_ERR_EN address checking)
module mem_responder #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_i,
    input  logic [31:0] mem_addr_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_be_i,
    input  logic [31:0] mem_wdata_i,
    output logic        mem_rvalid_o,
    output logic        mem_err_o,
    output logic [31:0] mem_rdata_o,
    output logic        busy_o,
    output logic [15:0] req_count_o
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN_BYTES = 32'(4 * DEPTH_WORDS);

    logic                accept;
    logic [31:0]         offset;
    logic [AW-1:0]       word_idx;
    logic                addr_err;
    logic [31:0]         rd_word;
    logic [31:0]         mem [DEPTH_WORDS];
    logic [LATENCY-1:0]  pipe_valid;
    logic [LATENCY-1:0]  pipe_err;
    logic [31:0]         pipe_rdata [LATENCY];
    logic [15:0]         req_count;

    // requests seen while reset is asserted are dropped entirely
    assign accept   = mem_req_i & rst;
    assign offset   = mem_addr_i - ADDR_BASE;
    // low two address bits are discarded; upper bits fold the index modulo the depth
    assign word_idx = AW'(offset >> 2);
    assign rd_word  = mem[word_idx];

`ifdef MEM_RESP_ERR_EN
    // addresses below the base wrap to huge offsets, so one compare covers both ends
    assign addr_err = (mem_addr_i[1:0] != 2'b00) || (offset >= SPAN_BYTES);
`else
    assign addr_err = 1'b0;
`endif

    // storage write with per-byte enables; contents survive reset
    always_ff @(posedge clk) begin
        if (accept && mem_we_i && !addr_err) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be_i[b]) begin
                    mem[word_idx][8*b +: 8] <= mem_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // response shift pipeline; stage 0 captures the pre-write read value at the accepting edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            pipe_valid <= '0;
            pipe_err   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_rdata[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= accept;
            pipe_err[0]   <= accept & addr_err;
            pipe_rdata[0] <= (accept && !mem_we_i && !addr_err) ? rd_word : 32'h0;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_err[i]   <= pipe_err[i-1];
                pipe_rdata[i] <= pipe_rdata[i-1];
            end
        end
    end

    // saturating count of accepted requests
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_count <= 16'h0000;
        end else if (accept && (req_count != 16'hFFFF)) begin
            req_count <= req_count + 16'd1;
        end
    end

    // a response reaching the output during a reset cycle is in flight and must not be emitted
    assign mem_rvalid_o = rst & pipe_valid[LATENCY-1];
    assign mem_err_o    = rst & pipe_err[LATENCY-1];
    assign mem_rdata_o  = rst ? pipe_rdata[LATENCY-1] : 32'h0;
    assign busy_o       = |pipe_valid;
    assign req_count_o  = req_count;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized model-checked bench for mem_responder (two latency/depth configurations)
module tb_mem_responder;

`ifdef MEM_RESP_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req_i = 1'b0;
    logic [31:0] mem_addr_i = 32'h0;
    logic        mem_we_i = 1'b0;
    logic [3:0]  mem_be_i = 4'h0;
    logic [31:0] mem_wdata_i = 32'h0;

    logic        a_rvalid, a_err, a_busy;
    logic [31:0] a_rdata;
    logic [15:0] a_count;
    logic        b_rvalid, b_err, b_busy;
    logic [31:0] b_rdata;
    logic [15:0] b_count;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_BASE(32'h0), .DEPTH_WORDS(1024), .LATENCY(2)) dut_a (
        .clk(clk), .rst(rst), .mem_req_i(mem_req_i), .mem_addr_i(mem_addr_i),
        .mem_we_i(mem_we_i), .mem_be_i(mem_be_i), .mem_wdata_i(mem_wdata_i),
        .mem_rvalid_o(a_rvalid), .mem_err_o(a_err), .mem_rdata_o(a_rdata),
        .busy_o(a_busy), .req_count_o(a_count));

    mem_responder #(.ADDR_BASE(32'h0), .DEPTH_WORDS(16), .LATENCY(3)) dut_b (
        .clk(clk), .rst(rst), .mem_req_i(mem_req_i), .mem_addr_i(mem_addr_i),
        .mem_we_i(mem_we_i), .mem_be_i(mem_be_i), .mem_wdata_i(mem_wdata_i),
        .mem_rvalid_o(b_rvalid), .mem_err_o(b_err), .mem_rdata_o(b_rdata),
        .busy_o(b_busy), .req_count_o(b_count));

    typedef struct {
        int          due;
        bit          err;
        logic [31:0] data;
    } resp_t;

    resp_t       qa[$];
    resp_t       qb[$];
    logic [31:0] ma [1024];
    logic [31:0] mb [16];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    bit          checking = 1'b0;
    logic [15:0] cnt = 16'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model: one entry per accepted request, due LATENCY cycles later
    always @(posedge clk) begin : model
        int    t;
        bit    e;
        int    ix;
        resp_t r;
        t = cyc;
        if (!rst) begin
            qa.delete();
            qb.delete();
            cnt = 16'h0;
        end else if (mem_req_i) begin
            e  = ERR_EN && ((mem_addr_i[1:0] != 2'b00) || (mem_addr_i >= 32'd4096));
            ix = int'((mem_addr_i >> 2) % 32'd1024);
            r.due  = t + 2;
            r.err  = e;
            r.data = (e || mem_we_i) ? 32'h0 : ma[ix];
            if (!e && mem_we_i)
                for (int k = 0; k < 4; k++)
                    if (mem_be_i[k]) ma[ix][8*k +: 8] = mem_wdata_i[8*k +: 8];
            qa.push_back(r);

            e  = ERR_EN && ((mem_addr_i[1:0] != 2'b00) || (mem_addr_i >= 32'd64));
            ix = int'((mem_addr_i >> 2) % 32'd16);
            r.due  = t + 3;
            r.err  = e;
            r.data = (e || mem_we_i) ? 32'h0 : mb[ix];
            if (!e && mem_we_i)
                for (int k = 0; k < 4; k++)
                    if (mem_be_i[k]) mb[ix][8*k +: 8] = mem_wdata_i[8*k +: 8];
            qb.push_back(r);

            if (cnt != 16'hFFFF) cnt = cnt + 16'd1;
        end
        cyc = cyc + 1;
    end

    // per-cycle comparison of both instances against the model
    always @(negedge clk) begin : compare
        bit ev;
        if (checking) begin
            ev = (qa.size() > 0) && (qa[0].due == cyc);
            check("a_rvalid", 32'(a_rvalid), 32'(ev && rst));
            check("a_err",    32'(a_err),    (ev && rst) ? 32'(qa[0].err) : 32'h0);
            check("a_rdata",  a_rdata,       (ev && rst) ? qa[0].data : 32'h0);
            check("a_busy",   32'(a_busy),   32'(qa.size() > 0));
            check("a_count",  32'(a_count),  32'(cnt));
            if (ev) void'(qa.pop_front());

            ev = (qb.size() > 0) && (qb[0].due == cyc);
            check("b_rvalid", 32'(b_rvalid), 32'(ev && rst));
            check("b_err",    32'(b_err),    (ev && rst) ? 32'(qb[0].err) : 32'h0);
            check("b_rdata",  b_rdata,       (ev && rst) ? qb[0].data : 32'h0);
            check("b_busy",   32'(b_busy),   32'(qb.size() > 0));
            check("b_count",  32'(b_count),  32'(cnt));
            if (ev) void'(qb.pop_front());
        end
    end

    task automatic drive(input bit req, input logic [31:0] addr, input bit we,
                         input logic [3:0] be, input logic [31:0] wd);
        @(posedge clk);
        #1;
        mem_req_i   = req;
        mem_addr_i  = addr;
        mem_we_i    = we;
        mem_be_i    = be;
        mem_wdata_i = wd;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    endtask

    task automatic rand_req(input bit force_req);
        logic [31:0] addr;
        bit          req;
        addr = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 'h4F)) : 32'($urandom_range(0, 'h11FF));
        req  = force_req || ($urandom_range(0, 3) != 0);
        drive(req, addr, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
    endtask

    initial begin : stimulus
        logic [11:0] vhist;
        logic [11:0] bhist;
        int          nv;

        repeat (3) @(posedge clk);
        #1;
        checking = 1'b1;
        rst = 1'b1;

        // fill every word so that later reads have defined contents
        for (int i = 0; i < 1024; i++) drive(1'b1, 32'(i * 4), 1'b1, 4'hF, $urandom);
        repeat (4) idle();

        // write then read same word: write response carries 0, read sees new data
        drive(1'b1, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF);
        drive(1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
        idle();
        @(negedge clk);
        check("lit_wr_rvalid", 32'(a_rvalid), 32'h1);
        check("lit_wr_rdata",  a_rdata, 32'h0);
        idle();
        @(negedge clk);
        check("lit_rd_rvalid", 32'(a_rvalid), 32'h1);
        check("lit_rd_rdata",  a_rdata, 32'hDEADBEEF);
        repeat (4) idle();

        // partial byte-enable merge
        drive(1'b1, 32'h20, 1'b1, 4'hF, 32'h11223344);
        drive(1'b1, 32'h20, 1'b1, 4'b0101, 32'hAABBCCDD);
        drive(1'b1, 32'h20, 1'b0, 4'h0, 32'h0);
        idle();
        idle();
        @(negedge clk);
        check("lit_be_rdata", a_rdata, 32'h11BB33DD);
        repeat (5) idle();

        // eight back-to-back reads on the latency-3 instance
        vhist = '0;
        bhist = '0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'(i * 4), 1'b0, 4'h0, 32'h0);
            @(negedge clk);
            vhist[i] = b_rvalid;
            bhist[i] = b_busy;
        end
        for (int j = 8; j < 12; j++) begin
            idle();
            @(negedge clk);
            vhist[j] = b_rvalid;
            bhist[j] = b_busy;
        end
        check("lit_burst_rvalid", 32'(vhist), 32'h7F8);
        check("lit_burst_busy",   32'(bhist), 32'h7FE);
        repeat (2) idle();

        // out-of-range and misaligned reads
        drive(1'b1, 32'h0, 1'b1, 4'hF, 32'h01234567);
        drive(1'b1, 32'h4, 1'b1, 4'hF, 32'h89ABCDEF);
        drive(1'b1, 32'h1000, 1'b0, 4'h0, 32'h0);
        drive(1'b1, 32'h6, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        idle();
        @(negedge clk);
        check("lit_oor_rvalid", 32'(a_rvalid), 32'h1);
        check("lit_oor_err",    32'(a_err), ERR_EN ? 32'h1 : 32'h0);
        check("lit_oor_rdata",  a_rdata, ERR_EN ? 32'h0 : 32'h01234567);
        idle();
        @(negedge clk);
        check("lit_mis_rvalid", 32'(a_rvalid), 32'h1);
        check("lit_mis_err",    32'(a_err), ERR_EN ? 32'h1 : 32'h0);
        check("lit_mis_rdata",  a_rdata, ERR_EN ? 32'h0 : 32'h89ABCDEF);
        repeat (4) idle();

        // reset with two requests in flight
        drive(1'b1, 32'h40, 1'b0, 4'h0, 32'h0);
        drive(1'b1, 32'h44, 1'b0, 4'h0, 32'h0);
        drive(1'b1, 32'h8, 1'b1, 4'hF, 32'hCAFEF00D);
        rst = 1'b0;
        @(negedge clk);
        nv = int'(a_rvalid) + int'(b_rvalid);
        idle();
        rst = 1'b1;
        @(negedge clk);
        check("lit_rst_busy_a", 32'(a_busy), 32'h0);
        check("lit_rst_busy_b", 32'(b_busy), 32'h0);
        check("lit_rst_count",  32'(a_count), 32'h0);
        for (int j = 0; j < 4; j++) begin
            idle();
            @(negedge clk);
            nv += int'(a_rvalid) + int'(b_rvalid);
        end
        check("lit_rst_no_rvalid", 32'(nv), 32'h0);

        // randomized traffic, then a saturating burst
        repeat (3000) rand_req(1'b0);
        repeat (65540) rand_req(1'b1);
        idle();
        @(negedge clk);
        check("lit_sat_a", 32'(a_count), 32'hFFFF);
        check("lit_sat_b", 32'(b_count), 32'hFFFF);
        repeat (3) rand_req(1'b1);
        idle();
        @(negedge clk);
        check("lit_sat_hold", 32'(a_count), 32'hFFFF);
        repeat (5) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
